// File: rtl/lisp_cons_heap_pkg.sv
// Shared types for the Lisp cons-cell heap: cell type tags, heap opcodes, FSM states
// and the poison pattern used when LISP_HEAP_POISON_EN is defined.
package lisp_cons_heap_pkg;

  // Cell layout: {type[TYPE_BITS-1:0], data[ADDR_WIDTH-1:0]}; cons = {car, cdr}.
  typedef enum logic [3:0] {
    TYPE_NIL    = 4'd0,
    TYPE_NUMBER = 4'd1,
    TYPE_SYMBOL = 4'd2,
    TYPE_CONS   = 4'd3
  } type_t;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_ALLOC = 2'b01,
    OP_FREE  = 2'b10,
    OP_WRITE = 2'b11
  } heap_op_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACCESS,
    ST_COMMIT,
    ST_RESP
  } heap_state_t;

  // 'hAF replicated; callers take the low ADDR_WIDTH bits as the poison data field.
  function automatic logic [127:0] poison_pattern();
    return {16{8'hAF}};
  endfunction

endpackage

// File: rtl/lisp_cons_heap_if.sv
// Request/response bundle between the evaluator (master) and the cons heap (slave).
interface lisp_cons_heap_if #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned TYPE_BITS  = 4
);
  localparam int unsigned CELL_W = TYPE_BITS + ADDR_WIDTH;
  localparam int unsigned CONS_W = 2 * CELL_W;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [CONS_W-1:0]     req_cons;
  logic                  rsp_valid;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic [CONS_W-1:0]     rsp_cons;
  logic                  rsp_err;
  logic [CNT_W-1:0]      free_count;
  logic                  init_done;

  modport master (
    output req_valid, req_op, req_addr, req_cons,
    input  req_ready, rsp_valid, rsp_addr, rsp_cons, rsp_err, free_count, init_done
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_cons,
    output req_ready, rsp_valid, rsp_addr, rsp_cons, rsp_err, free_count, init_done
  );

endinterface

// File: rtl/lisp_heap_ram.sv
// Single-port cons storage: synchronous write, registered read (read-before-write).
module lisp_heap_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 40,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  always_comb begin
    rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lisp_cons_heap.sv
// Cons-cell heap with hardware free list; serves READ/ALLOC/FREE/WRITE over valid/ready.
// Optional LISP_HEAP_POISON_EN: FREE poisons the car, accesses to poisoned slots are rejected.
module lisp_cons_heap
  import lisp_cons_heap_pkg::*;
#(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned TYPE_BITS  = 4
) (
  input  logic             clk,
  input  logic             rst,
  lisp_cons_heap_if.slave  bus
);

  localparam int unsigned CELL_W = TYPE_BITS + ADDR_WIDTH;
  localparam int unsigned CONS_W = 2 * CELL_W;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

  heap_state_t           state_q, state_d;
  logic [IDX_W-1:0]      init_idx_q, init_idx_d;
  logic [IDX_W-1:0]      head_q, head_d;
  logic [CNT_W-1:0]      free_count_q, free_count_d;
  logic                  init_done_q, init_done_d;
  logic                  req_ready_q, req_ready_d;
  heap_op_t              op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CONS_W-1:0]     cons_q, cons_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic [CONS_W-1:0]     rsp_cons_q, rsp_cons_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [IDX_W-1:0]      ram_addr;
  logic                  ram_we;
  logic [CONS_W-1:0]     ram_wdata;
  logic [CONS_W-1:0]     ram_rdata;

  logic [IDX_W-1:0]      init_next;
  logic [CELL_W-1:0]     rd_car;
  logic [CELL_W-1:0]     free_car;
  logic                  addr_ok;
  logic                  poisoned;

  lisp_heap_ram #(
    .DEPTH (DEPTH),
    .WIDTH (CONS_W)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign init_next = init_idx_q + IDX_W'(1);
  assign rd_car    = ram_rdata[CONS_W-1:CELL_W];
  assign addr_ok   = (addr_q != '0) && ({1'b0, addr_q} < DEPTH_EXT);

`ifdef LISP_HEAP_POISON_EN
  localparam logic [127:0]       POISON_PAT  = poison_pattern();
  localparam logic [CELL_W-1:0]  POISON_CELL = {{TYPE_BITS{1'b0}}, POISON_PAT[ADDR_WIDTH-1:0]};
  assign poisoned = (rd_car == POISON_CELL);
  assign free_car = POISON_CELL;
`else
  assign poisoned = 1'b0;
  assign free_car = rd_car;
`endif

  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    head_d       = head_q;
    free_count_d = free_count_q;
    init_done_d  = init_done_q;
    req_ready_d  = 1'b0;
    op_d         = op_q;
    addr_d       = addr_q;
    cons_d       = cons_q;
    rsp_valid_d  = 1'b0;
    rsp_addr_d   = rsp_addr_q;
    rsp_cons_d   = rsp_cons_q;
    rsp_err_d    = rsp_err_q;
    ram_addr     = head_q;
    ram_we       = 1'b0;
    ram_wdata    = '0;

    case (state_q)
      ST_INIT: begin
        // Last slot's successor wraps to 0, which is the free-list terminator.
        ram_addr  = init_idx_q;
        ram_we    = 1'b1;
        ram_wdata = {{CELL_W{1'b0}}, {TYPE_BITS{1'b0}}, ADDR_WIDTH'(init_next)};
        if (init_idx_q == LAST_IDX) begin
          state_d      = ST_IDLE;
          head_d       = IDX_W'(1);
          free_count_d = CNT_W'(DEPTH - 1);
          init_done_d  = 1'b1;
        end else begin
          init_idx_d = init_next;
        end
      end

      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          op_d        = heap_op_t'(bus.req_op);
          addr_d      = bus.req_addr;
          cons_d      = bus.req_cons;
          req_ready_d = 1'b0;
          state_d     = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        ram_addr = (op_q == OP_ALLOC) ? head_q : addr_q[IDX_W-1:0];
        state_d  = ST_COMMIT;
      end

      ST_COMMIT: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_addr_d  = addr_q;
        rsp_cons_d  = '0;
        rsp_err_d   = 1'b0;
        case (op_q)
          OP_READ: begin
            if (!addr_ok || poisoned) rsp_err_d = 1'b1;
            else                      rsp_cons_d = ram_rdata;
          end
          OP_ALLOC: begin
            if (free_count_q == '0) begin
              rsp_err_d  = 1'b1;
              rsp_addr_d = '0;
            end else begin
              ram_addr     = head_q;
              ram_we       = 1'b1;
              ram_wdata    = cons_q;
              head_d       = ram_rdata[IDX_W-1:0];
              free_count_d = free_count_q - CNT_W'(1);
              rsp_addr_d   = ADDR_WIDTH'(head_q);
            end
          end
          OP_FREE: begin
            if (!addr_ok || poisoned) begin
              rsp_err_d = 1'b1;
            end else begin
              ram_addr     = addr_q[IDX_W-1:0];
              ram_we       = 1'b1;
              ram_wdata    = {free_car, {TYPE_BITS{1'b0}}, ADDR_WIDTH'(head_q)};
              head_d       = addr_q[IDX_W-1:0];
              free_count_d = free_count_q + CNT_W'(1);
            end
          end
          default: begin
            if (!addr_ok || poisoned) begin
              rsp_err_d = 1'b1;
            end else begin
              ram_addr  = addr_q[IDX_W-1:0];
              ram_we    = 1'b1;
              ram_wdata = cons_q;
            end
          end
        endcase
      end

      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end

      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      init_idx_q   <= IDX_W'(1);
      head_q       <= '0;
      free_count_q <= '0;
      init_done_q  <= 1'b0;
      req_ready_q  <= 1'b0;
      op_q         <= OP_READ;
      addr_q       <= '0;
      cons_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_addr_q   <= '0;
      rsp_cons_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      head_q       <= head_d;
      free_count_q <= free_count_d;
      init_done_q  <= init_done_d;
      req_ready_q  <= req_ready_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      cons_q       <= cons_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_addr_q   <= rsp_addr_d;
      rsp_cons_q   <= rsp_cons_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_addr   = rsp_addr_q;
  assign bus.rsp_cons   = rsp_cons_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.free_count = free_count_q;
  assign bus.init_done  = init_done_q;

endmodule

// File: tb/tb_lisp_cons_heap.sv
// Scoreboard bench for lisp_cons_heap: a queue/array heap model predicts each response,
// a monitor compares whenever rsp_valid pulses.
module tb_lisp_cons_heap;
  import lisp_cons_heap_pkg::*;

  localparam int unsigned DEPTH      = 256;
  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned TYPE_BITS  = 4;
  localparam int unsigned CELL_W     = TYPE_BITS + ADDR_WIDTH;
  localparam int unsigned CONS_W     = 2 * CELL_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lisp_cons_heap_if #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .TYPE_BITS(TYPE_BITS)) bus ();

  lisp_cons_heap #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .TYPE_BITS(TYPE_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [CONS_W-1:0]     cons;
    logic                  err;
    int unsigned           fc;
    int unsigned           due;
  } exp_t;

  exp_t        sb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc    = 0;

  // Reference heap: contents array, free list as a LIFO queue (front = head).
  logic [CONS_W-1:0] m_mem [DEPTH];
  int                m_free[$];
  int                m_used[$];
  bit                m_poison [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_free.delete();
    m_used.delete();
    for (int i = 1; i < DEPTH; i++) m_free.push_back(i);
    for (int i = 0; i < DEPTH; i++) m_poison[i] = 1'b0;
  endtask

  function automatic logic [CONS_W-1:0] rand_cons();
    logic [63:0]       r;
    logic [CONS_W-1:0] c;
    r = {$urandom, $urandom};
    c = r[CONS_W-1:0];
    c[CONS_W-1 -: TYPE_BITS] = TYPE_BITS'(1);
    return c;
  endfunction

  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: rsp_valid=1 with no request outstanding (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_addr",   64'(bus.rsp_addr),   64'(e.addr));
        check("rsp_cons",   64'(bus.rsp_cons),   64'(e.cons));
        check("rsp_err",    64'(bus.rsp_err),    64'(e.err));
        check("free_count", 64'(bus.free_count), 64'(e.fc));
        check("rsp_cycle",  64'(cyc),            64'(e.due));
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int unsigned w;
    w = 0;
    while (!bus.req_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    ok = bus.req_ready;
    if (!ok) check("ready_timeout", 64'(0), 64'(1));
  endtask

  task automatic issue(input logic [1:0] op, input int addr, input logic [CONS_W-1:0] cons);
    exp_t        e;
    bit          bad;
    bit          ok;
    int          a;
    int unsigned acc;
    int unsigned w;
    int          idx[$];
    bad = (addr == 0) || (addr >= DEPTH);
`ifdef LISP_HEAP_POISON_EN
    if (!bad) bad = m_poison[addr];
`endif
    e.addr = ADDR_WIDTH'(addr);
    e.cons = '0;
    e.err  = 1'b0;
    case (op)
      2'b00: if (bad) e.err = 1'b1; else e.cons = m_mem[addr];
      2'b01: begin
        if (m_free.size() == 0) begin
          e.err  = 1'b1;
          e.addr = '0;
        end else begin
          a = m_free.pop_front();
          m_mem[a] = cons;
          m_poison[a] = 1'b0;
          m_used.push_back(a);
          e.addr = ADDR_WIDTH'(a);
        end
      end
      2'b10: begin
        if (bad) e.err = 1'b1;
        else begin
          m_free.push_front(addr);
          idx = m_used.find_first_index(x) with (x == addr);
          if (idx.size() > 0) m_used.delete(idx[0]);
`ifdef LISP_HEAP_POISON_EN
          m_poison[addr] = 1'b1;
`endif
        end
      end
      default: if (bad) e.err = 1'b1; else m_mem[addr] = cons;
    endcase
    e.fc = m_free.size();

    wait_ready(ok);
    if (!ok) return;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = ADDR_WIDTH'(addr);
    bus.req_cons  = cons;
    e.due = cyc + 3;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    acc = cyc;
    w = 0;
    while (!bus.req_ready && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    check("ready_gap", 64'(cyc - acc), 64'(3));
  endtask

  task automatic wait_init();
    int unsigned n;
    n = 0;
    while (!bus.init_done && n < DEPTH + 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("init_latency", 64'(n), 64'(DEPTH - 1));
    check("init_free_count", 64'(bus.free_count), 64'(DEPTH - 1));
    check("ready_at_init_done", 64'(bus.req_ready), 64'(0));
    @(posedge clk); #1;
    check("ready_after_init", 64'(bus.req_ready), 64'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  64'(bus.req_ready),  64'(0));
    check({tag, "_rsp_valid"},  64'(bus.rsp_valid),  64'(0));
    check({tag, "_rsp_addr"},   64'(bus.rsp_addr),   64'(0));
    check({tag, "_rsp_cons"},   64'(bus.rsp_cons),   64'(0));
    check({tag, "_rsp_err"},    64'(bus.rsp_err),    64'(0));
    check({tag, "_free_count"}, 64'(bus.free_count), 64'(0));
    check({tag, "_init_done"},  64'(bus.init_done),  64'(0));
  endtask

  initial begin
    int          r;
    int          a;
    bit          ok;
    int unsigned w;
    logic [CONS_W-1:0] num42;

    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_addr  = '0;
    bus.req_cons  = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_init();

    // Directed: fresh allocation order, write/read, LIFO reuse, rejected requests.
    repeat (3) issue(2'b01, 0, rand_cons());
    num42 = {TYPE_BITS'(1), ADDR_WIDTH'(16'h0042), TYPE_BITS'(0), ADDR_WIDTH'(0)};
    issue(2'b11, 2, num42);
    issue(2'b00, 2, '0);
    issue(2'b10, 2, '0);
    issue(2'b01, 0, rand_cons());
    issue(2'b00, 0, '0);
    issue(2'b10, 300, '0);
    issue(2'b11, 0, rand_cons());
`ifdef LISP_HEAP_POISON_EN
    issue(2'b10, 3, '0);
    issue(2'b10, 3, '0);
    issue(2'b00, 3, '0);
    issue(2'b11, 3, rand_cons());
    issue(2'b01, 0, rand_cons());
`endif

    // Random well-formed traffic plus out-of-range addresses.
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      if (m_used.size() == 0 || r < 30) begin
        issue(2'b01, 0, rand_cons());
      end else if (r < 90) begin
        a = m_used[$urandom_range(0, m_used.size() - 1)];
        if (r < 50)      issue(2'b11, a, rand_cons());
        else if (r < 75) issue(2'b00, a, '0);
        else             issue(2'b10, a, '0);
      end else begin
        a = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(DEPTH, 65535));
        issue(2'($urandom_range(0, 1) * 2 + $urandom_range(0, 1) * (($urandom_range(0, 1) == 1) ? 1 : 0) * 0 + (($urandom_range(0, 1) == 1) ? 0 : 0)), a, rand_cons());
      end
    end

    // Exhaust the heap, then one more ALLOC must be rejected.
    while (m_free.size() > 0) issue(2'b01, 0, rand_cons());
    issue(2'b01, 0, rand_cons());
    issue(2'b00, m_used[0], '0);
    issue(2'b10, m_used[0], '0);
    issue(2'b10, m_used[m_used.size() - 1], '0);
    issue(2'b01, 0, rand_cons());

    // Reset during an accepted ALLOC: no response may follow, INIT reruns.
    w = 0;
    while (sb.size() > 0 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    wait_ready(ok);
    if (ok) begin
      bus.req_valid = 1'b1;
      bus.req_op    = 2'b01;
      bus.req_addr  = '0;
      bus.req_cons  = rand_cons();
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("midop_reset");
      rst = 1'b0;
      model_reset();
      wait_init();
      issue(2'b01, 0, rand_cons());
    end

    w = 0;
    while (sb.size() > 0 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("scoreboard_drain", 64'(sb.size()), 64'(0));
    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
